// File: rtl/mem_route_demux_if.sv
// Host-side request bus, SRAM strobes and MMIO register outputs for mem_route_demux.
// The slave modport is the demux's view and the master modport is the requester's view.
interface mem_route_demux_if;
    localparam int unsigned DW = 16;

    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] led_reg;
    logic [DW-1:0] hex_reg;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_oe, rdata, busy, done, led_reg, hex_reg
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_oe, rdata, busy, done, led_reg, hex_reg
    );
endinterface

// File: rtl/mem_route_demux.sv
// Routes single host transactions either to an SRAM with a fixed access time
// or to a small MMIO register block at the top of the address map.
module mem_route_demux #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic               Clk,
    input logic               Reset,
    mem_route_demux_if.slave  bus
);
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [DW-1:0] ADDR_LED   = 16'hFFFF;
    localparam logic [DW-1:0] ADDR_HEX   = 16'hFFFE;
    localparam logic [DW-1:0] ADDR_WRCNT = 16'hFFFD;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [DW-1:0]    write_count;

    logic             is_mmio_c;
    logic [DW-1:0]    mmio_rdata_c;

    // The MMIO window is 0xFE00..0xFFFF, i.e. the top seven address bits all set.
    always_comb begin
        is_mmio_c    = (bus.addr[DW-1:9] == 7'h7F);
        mmio_rdata_c = '0;
        case (bus.addr)
            ADDR_LED:   mmio_rdata_c = bus.led_reg;
            ADDR_HEX:   mmio_rdata_c = bus.hex_reg;
            ADDR_WRCNT: mmio_rdata_c = write_count;
            default:    mmio_rdata_c = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            write_count   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_oe    <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.led_reg   <= '0;
            bus.hex_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        bus.busy <= 1'b1;
                        if (is_mmio_c) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            if (bus.we) begin
                                if (bus.addr == ADDR_LED) begin
                                    bus.led_reg <= bus.wdata;
                                end else if (bus.addr == ADDR_HEX) begin
                                    bus.hex_reg <= bus.wdata;
                                end
                            end else begin
                                bus.rdata <= mmio_rdata_c;
                            end
                        end else begin
                            state         <= MEM_WAIT;
                            wait_cnt      <= CNT_LOAD;
                            bus.mem_addr  <= bus.addr;
                            bus.mem_wdata <= bus.wdata;
                            bus.mem_we    <= bus.we;
                            bus.mem_oe    <= !bus.we;
                        end
                    end
                end

                // mem_we holds the latched direction for the whole access.
                MEM_WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= DONE;
                        bus.done   <= 1'b1;
                        bus.mem_we <= 1'b0;
                        bus.mem_oe <= 1'b0;
                        if (bus.mem_we) begin
                            write_count <= write_count + 16'd1;
                        end else begin
                            bus.rdata <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_route_demux.sv
// Directed bench for mem_route_demux: a table of single transactions followed by
// hand-written sequences for overlap, mid-transaction reset and counter wrap.
module tb_mem_route_demux;
    localparam int unsigned WAIT = 2;
    localparam int          NVEC = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_route_demux_if bus ();

    mem_route_demux #(.WAIT_CYCLES(WAIT)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrd;
        int          lat;
        logic [15:0] rdata;
        logic [15:0] led;
        logic [15:0] hex;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes must never be active together
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_checks++;
            if (bus.mem_we === 1'b1 && bus.mem_oe === 1'b1) begin
                n_fail++;
                $display("FAIL strobe_overlap: mem_we=1 mem_oe=1 expected not both at %0t", $time);
            end
        end
    end

    // One transaction issued in IDLE; returns the cycle done was seen (-1 on timeout).
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] mrd, output int lat);
        bit is_mem;
        is_mem        = (addr < 16'hFE00);
        bus.req       = 1'b1;
        bus.we        = we;
        bus.addr      = addr;
        bus.wdata     = wdata;
        bus.mem_rdata = mrd;
        tick();
        bus.req = 1'b0;
        lat     = -1;
        for (int c = 1; c <= 40; c++) begin
            check("busy_active", 16'(bus.busy), 16'd1);
            if (is_mem && c <= int'(WAIT)) begin
                check("strobes_wait", 16'({bus.mem_we, bus.mem_oe}), 16'({we, !we}));
                check("mem_addr", bus.mem_addr, addr);
                if (we) check("mem_wdata", bus.mem_wdata, wdata);
            end else begin
                check("strobes_idle", 16'({bus.mem_we, bus.mem_oe}), 16'd0);
            end
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        tick();
        check("busy_after", 16'(bus.busy), 16'd0);
        check("done_after", 16'(bus.done), 16'd0);
    endtask

    initial begin
        int lat;
        int dones;

        vecs[0]  = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 1, 16'h0000, 16'h00A5, 16'h0000};
        vecs[1]  = '{1'b1, 16'hFFFE, 16'h1357, 16'h0000, 1, 16'h0000, 16'h00A5, 16'h1357};
        vecs[2]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, 16'h00A5, 16'h00A5, 16'h1357};
        vecs[3]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1, 16'h1357, 16'h00A5, 16'h1357};
        vecs[4]  = '{1'b1, 16'h1000, 16'hBEEF, 16'hDEAD, 3, 16'h1357, 16'h00A5, 16'h1357};
        vecs[5]  = '{1'b1, 16'hFDFF, 16'h0001, 16'hDEAD, 3, 16'h1357, 16'h00A5, 16'h1357};
        vecs[6]  = '{1'b1, 16'h0000, 16'h0002, 16'hDEAD, 3, 16'h1357, 16'h00A5, 16'h1357};
        vecs[7]  = '{1'b0, 16'hFFFD, 16'h0000, 16'h0000, 1, 16'h0003, 16'h00A5, 16'h1357};
        vecs[8]  = '{1'b0, 16'hFE10, 16'h0000, 16'h0000, 1, 16'h0000, 16'h00A5, 16'h1357};
        vecs[9]  = '{1'b1, 16'hFFFD, 16'h0055, 16'h0000, 1, 16'h0000, 16'h00A5, 16'h1357};
        vecs[10] = '{1'b0, 16'hFFFD, 16'h0000, 16'h0000, 1, 16'h0003, 16'h00A5, 16'h1357};
        vecs[11] = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 3, 16'h1234, 16'h00A5, 16'h1357};
        vecs[12] = '{1'b1, 16'hFE00, 16'h9999, 16'h0000, 1, 16'h1234, 16'h00A5, 16'h1357};
        vecs[13] = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, 16'h0000, 16'h00A5, 16'h1357};
        vecs[14] = '{1'b0, 16'hFDFF, 16'h0000, 16'hABCD, 3, 16'hABCD, 16'h00A5, 16'h1357};
        vecs[15] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1, 16'hABCD, 16'h5A5A, 16'h1357};

        bus.req       = 1'b0;
        bus.we        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy",      16'(bus.busy),   16'd0);
        check("rst_done",      16'(bus.done),   16'd0);
        check("rst_mem_we",    16'(bus.mem_we), 16'd0);
        check("rst_mem_oe",    16'(bus.mem_oe), 16'd0);
        check("rst_rdata",     bus.rdata,       16'h0000);
        check("rst_mem_addr",  bus.mem_addr,    16'h0000);
        check("rst_mem_wdata", bus.mem_wdata,   16'h0000);
        check("rst_led",       bus.led_reg,     16'h0000);
        check("rst_hex",       bus.hex_reg,     16'h0000);

        for (int i = 0; i < NVEC; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mrd, lat);
            check($sformatf("v%0d_latency", i), 16'(lat), 16'(vecs[i].lat));
            check($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].rdata);
            check($sformatf("v%0d_led", i), bus.led_reg, vecs[i].led);
            check($sformatf("v%0d_hex", i), bus.hex_reg, vecs[i].hex);
        end

        // A second req during MEM_WAIT is dropped
        dones         = 0;
        bus.req       = 1'b1;
        bus.we        = 1'b0;
        bus.addr      = 16'h2000;
        bus.mem_rdata = 16'h4444;
        tick();
        bus.we    = 1'b1;
        bus.addr  = 16'h5000;
        bus.wdata = 16'h7777;
        for (int c = 1; c <= 8; c++) begin
            if (c <= int'(WAIT)) begin
                check("ovl_mem_addr", bus.mem_addr, 16'h2000);
                check("ovl_strobes", 16'({bus.mem_we, bus.mem_oe}), 16'b01);
            end
            if (bus.done === 1'b1) dones++;
            if (c == int'(WAIT)) bus.req = 1'b0;
            tick();
        end
        check("ovl_done_count", 16'(dones), 16'd1);
        check("ovl_rdata", bus.rdata, 16'h4444);
        check("ovl_busy", 16'(bus.busy), 16'd0);
        txn(1'b0, 16'hFFFD, 16'h0000, 16'h0000, lat);
        check("ovl_wrcnt", bus.rdata, 16'h0003);

        // Reset during the first MEM_WAIT cycle of a write
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h0100;
        bus.wdata = 16'h1111;
        tick();
        bus.req = 1'b0;
        check("abort_mem_we_pre", 16'(bus.mem_we), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",     16'(bus.busy),   16'd0);
        check("abort_mem_we",   16'(bus.mem_we), 16'd0);
        check("abort_done",     16'(bus.done),   16'd0);
        check("abort_mem_addr", bus.mem_addr,    16'h0000);
        check("abort_led",      bus.led_reg,     16'h0000);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        check("abort_no_done", 16'(dones), 16'd0);
        txn(1'b0, 16'hFFFD, 16'h0000, 16'h0000, lat);
        check("abort_wrcnt", bus.rdata, 16'h0000);

        // Counter preset to 0xFFFF stands in for 65535 prior writes
        @(negedge clk);
        force dut.write_count = 16'hFFFF;
        tick();
        release dut.write_count;
        txn(1'b0, 16'hFFFD, 16'h0000, 16'h0000, lat);
        check("wrap_pre", bus.rdata, 16'hFFFF);
        txn(1'b1, 16'h0200, 16'h2222, 16'h0000, lat);
        check("wrap_wr_latency", 16'(lat), 16'(WAIT + 1));
        txn(1'b0, 16'hFFFD, 16'h0000, 16'h0000, lat);
        check("wrap_post", bus.rdata, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
